// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared core widths and the fetch queue entry type
// Exports: XLEN (address/PC width), fetch_entry_t {pc, instr}.
package riscv_pkg;

  localparam int XLEN = 32;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - power-of-two entry queue holding fetched instructions
// Ports: clk, rst (async, active-high); push/push_data write the tail;
// pop retires the head; clear empties the queue; head_data shows the head
// entry combinationally; count is the current occupancy (0..DEPTH).
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             clear,
  output logic [WIDTH-1:0] head_data,
  output logic [CW-1:0]    count
);

  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr] <= push_data;
  end

  assign head_data = mem[rd_ptr];

  // The fetch credit scheme never lets a response arrive into a full queue.
  assert property (@(posedge clk) disable iff (rst)
                   !(push && !pop && !clear && count == FULL));

endmodule

// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - credit-based instruction fetch with in-order tag list and flush
// Ports: clk, reset (async, active-high), reset_adr_i (first PC);
// icache_req_o/icache_adr_o/icache_gnt_i request channel;
// icache_rvalid_i/icache_instr_i in-order response channel;
// flush_v_i/flush_pc_i redirect; instr_v_o/instr_o/pc_o/dec_ready_i decoder side.
module fetch_buffer
  import riscv_pkg::*;
#(
  parameter int XLEN    = riscv_pkg::XLEN,
  parameter int DEPTH   = 4,
  parameter int MAX_OUT = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] reset_adr_i,
  output logic            icache_req_o,
  output logic [XLEN-1:0] icache_adr_o,
  input  logic            icache_gnt_i,
  input  logic            icache_rvalid_i,
  input  logic [31:0]     icache_instr_i,
  input  logic            flush_v_i,
  input  logic [XLEN-1:0] flush_pc_i,
  output logic            instr_v_o,
  output logic [31:0]     instr_o,
  output logic [XLEN-1:0] pc_o,
  input  logic            dec_ready_i
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int TW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam logic [CW:0]   DEPTH_W = (CW + 1)'(DEPTH);
  localparam logic [CW-1:0] MAX_W   = CW'(MAX_OUT);

  logic [XLEN-1:0] fpc;
  logic [CW-1:0]   count;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   discard;
  logic [XLEN-1:0] tag_mem [MAX_OUT];
  logic [TW-1:0]   tag_rd;
  logic [TW-1:0]   tag_wr;
  logic            grant;
  logic            q_push;
  logic            q_pop;
  fetch_entry_t    push_entry;
  fetch_entry_t    head_entry;

  function automatic logic [TW-1:0] tag_next(input logic [TW-1:0] p);
    return (p == TW'(MAX_OUT - 1)) ? '0 : p + TW'(1);
  endfunction

  // Queue slots already filled plus slots promised to in-flight requests
  // must stay within DEPTH, so a response always finds room.
  assign icache_req_o = !reset && !flush_v_i
                        && (({1'b0, count} + {1'b0, outstanding}) < DEPTH_W)
                        && (outstanding < MAX_W);
  assign icache_adr_o = fpc;
  assign grant        = icache_req_o && icache_gnt_i;

  // Responses that belong to requests issued before a flush are dropped
  // until discard drains; a response in the flush cycle itself is dropped.
  assign q_push = icache_rvalid_i && !flush_v_i && (discard == '0);
  assign q_pop  = instr_v_o && dec_ready_i && !flush_v_i;

  assign push_entry.pc    = tag_mem[tag_rd];
  assign push_entry.instr = icache_instr_i;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fpc         <= reset_adr_i;
      outstanding <= '0;
      discard     <= '0;
      tag_rd      <= '0;
      tag_wr      <= '0;
    end else begin
      if (flush_v_i)  fpc <= {flush_pc_i[XLEN-1:2], 2'b00};
      else if (grant) fpc <= fpc + XLEN'(4);

      if (grant && !icache_rvalid_i)      outstanding <= outstanding + CW'(1);
      else if (!grant && icache_rvalid_i) outstanding <= outstanding - CW'(1);

      // Every request still in flight after this cycle must be discarded.
      if (flush_v_i)                              discard <= outstanding - CW'(icache_rvalid_i);
      else if (icache_rvalid_i && discard != '0)  discard <= discard - CW'(1);

      // Tags stay in step with the icache across flushes; only reset clears them.
      if (grant)           tag_wr <= tag_next(tag_wr);
      if (icache_rvalid_i) tag_rd <= tag_next(tag_rd);
    end
  end

  always_ff @(posedge clk) begin
    if (grant) tag_mem[tag_wr] <= fpc;
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_fifo (
    .clk       (clk),
    .rst       (reset),
    .push      (q_push),
    .push_data (push_entry),
    .pop       (q_pop),
    .clear     (flush_v_i),
    .head_data (head_entry),
    .count     (count)
  );

  assign instr_v_o = (count != '0);
  assign instr_o   = instr_v_o ? head_entry.instr : '0;
  assign pc_o      = instr_v_o ? head_entry.pc    : '0;

endmodule

// File: tb/tb_fetch_buffer.sv
// tb/tb_fetch_buffer.sv - directed self-checking bench for fetch_buffer
module tb_fetch_buffer;

    logic        clk;
    logic        reset;
    logic [31:0] reset_adr_i;
    logic        icache_req_o;
    logic [31:0] icache_adr_o;
    logic        icache_gnt_i;
    logic        icache_rvalid_i;
    logic [31:0] icache_instr_i;
    logic        flush_v_i;
    logic [31:0] flush_pc_i;
    logic        instr_v_o;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic        dec_ready_i;

    int vecs = 0;
    int errs = 0;

    fetch_buffer dut (
        .clk             (clk),
        .reset           (reset),
        .reset_adr_i     (reset_adr_i),
        .icache_req_o    (icache_req_o),
        .icache_adr_o    (icache_adr_o),
        .icache_gnt_i    (icache_gnt_i),
        .icache_rvalid_i (icache_rvalid_i),
        .icache_instr_i  (icache_instr_i),
        .flush_v_i       (flush_v_i),
        .flush_pc_i      (flush_pc_i),
        .instr_v_o       (instr_v_o),
        .instr_o         (instr_o),
        .pc_o            (pc_o),
        .dec_ready_i     (dec_ready_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] io(input logic [31:0] a);
        return a ^ 32'h5A5A_0013;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        if (obs !== exp) begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic g, input logic rv, input logic [31:0] ins,
                       input logic fl, input logic [31:0] fpc, input logic rdy);
        icache_gnt_i    = g;
        icache_rvalid_i = rv;
        icache_instr_i  = ins;
        flush_v_i       = fl;
        flush_pc_i      = fpc;
        dec_ready_i     = rdy;
        #1;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [31:0] adr);
        reset_adr_i     = adr;
        reset           = 1'b1;
        icache_gnt_i    = 1'b0;
        icache_rvalid_i = 1'b0;
        icache_instr_i  = '0;
        flush_v_i       = 1'b0;
        flush_pc_i      = '0;
        dec_ready_i     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        reset_adr_i = 32'h8000_0000;
        icache_gnt_i = 0; icache_rvalid_i = 0; icache_instr_i = 0;
        flush_v_i = 0; flush_pc_i = 0; dec_ready_i = 0;
        #1 reset = 1'b1;
        #2;
        chk("rst_req", icache_req_o, 1'b0);
        chk("rst_v", instr_v_o, 1'b0);
        chk("rst_instr", instr_o, 32'h0);
        chk("rst_pc", pc_o, 32'h0);
        chk("rst_adr", icache_adr_o, 32'h8000_0000);

        do_reset(32'h8000_0000);
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, (i > 0), io(32'h8000_0000 + 32'(4 * (i - 1))), 1'b0, 32'h0, 1'b1);
            chk("seq_req", icache_req_o, 1'b1);
            chk("seq_adr", icache_adr_o, 32'h8000_0000 + 32'(4 * i));
            if (i >= 2) begin
                chk("seq_v", instr_v_o, 1'b1);
                chk("seq_pc", pc_o, 32'h8000_0000 + 32'(4 * (i - 2)));
                chk("seq_instr", instr_o, io(32'h8000_0000 + 32'(4 * (i - 2))));
            end
            tick;
        end

        do_reset(32'h1000);
        cyc(1, 0, 0, 0, 0, 0);            chk("bp_req0", icache_req_o, 1'b1); chk("bp_adr0", icache_adr_o, 32'h1000); tick;
        cyc(1, 1, io(32'h1000), 0, 0, 0); chk("bp_req1", icache_req_o, 1'b1); chk("bp_adr1", icache_adr_o, 32'h1004); tick;
        cyc(1, 1, io(32'h1004), 0, 0, 0); chk("bp_req2", icache_req_o, 1'b1); chk("bp_adr2", icache_adr_o, 32'h1008); tick;
        cyc(1, 1, io(32'h1008), 0, 0, 0); chk("bp_req3", icache_req_o, 1'b1); chk("bp_adr3", icache_adr_o, 32'h100C);
                                          chk("bp_pc3", pc_o, 32'h1000); tick;
        cyc(1, 1, io(32'h100C), 0, 0, 0); chk("bp_req4", icache_req_o, 1'b0); tick;
        cyc(1, 0, 0, 0, 0, 0);            chk("bp_req5", icache_req_o, 1'b0); chk("bp_v5", instr_v_o, 1'b1);
                                          chk("bp_pc5", pc_o, 32'h1000); chk("bp_instr5", instr_o, io(32'h1000)); tick;
        cyc(1, 0, 0, 0, 0, 1);            chk("bp_req6", icache_req_o, 1'b0); tick;
        cyc(1, 0, 0, 0, 0, 0);            chk("bp_req7", icache_req_o, 1'b1); chk("bp_adr7", icache_adr_o, 32'h1010);
                                          chk("bp_pc7", pc_o, 32'h1004); tick;
        cyc(1, 1, io(32'h1010), 0, 0, 0); chk("bp_req8", icache_req_o, 1'b0); tick;
        cyc(1, 0, 0, 0, 0, 1);            chk("bp_req9", icache_req_o, 1'b0); chk("bp_pc9", pc_o, 32'h1004); tick;
        cyc(0, 0, 0, 0, 0, 0);            chk("bp_v10", instr_v_o, 1'b1); chk("bp_pc10", pc_o, 32'h1008);
                                          chk("bp_req10", icache_req_o, 1'b1);

        reset_adr_i = 32'h2000;
        #2 reset = 1'b1;
        #1;
        chk("ar_v", instr_v_o, 1'b0);
        chk("ar_pc", pc_o, 32'h0);
        chk("ar_instr", instr_o, 32'h0);
        chk("ar_req", icache_req_o, 1'b0);
        chk("ar_adr", icache_adr_o, 32'h2000);

        do_reset(32'h2000);
        for (int i = 0; i < 10; i++) begin
            cyc(0, 0, 0, 0, 0, 1);
            chk("hold_req", icache_req_o, 1'b1);
            chk("hold_adr", icache_adr_o, 32'h2000);
            chk("hold_v", instr_v_o, 1'b0);
            tick;
        end

        do_reset(32'h100);
        cyc(1, 0, 0, 0, 0, 0);                   chk("f1_adr0", icache_adr_o, 32'h100); tick;
        cyc(1, 0, 0, 0, 0, 0);                   chk("f1_adr1", icache_adr_o, 32'h104); chk("f1_req1", icache_req_o, 1'b1); tick;
        cyc(1, 0, 0, 1, 32'h200, 0);             chk("f1_req2", icache_req_o, 1'b0); tick;
        cyc(1, 1, 32'hDEAD_0001, 0, 0, 0);       chk("f1_req3", icache_req_o, 1'b0); chk("f1_adr3", icache_adr_o, 32'h200);
                                                 chk("f1_v3", instr_v_o, 1'b0); tick;
        cyc(1, 1, 32'hDEAD_0002, 0, 0, 0);       chk("f1_req4", icache_req_o, 1'b1); chk("f1_v4", instr_v_o, 1'b0); tick;
        cyc(0, 1, io(32'h200), 0, 0, 0);         chk("f1_v5", instr_v_o, 1'b0); tick;
        cyc(0, 0, 0, 0, 0, 0);                   chk("f1_v6", instr_v_o, 1'b1); chk("f1_pc6", pc_o, 32'h200);
                                                 chk("f1_instr6", instr_o, io(32'h200)); tick;

        do_reset(32'h300);
        cyc(1, 0, 0, 0, 0, 0);                   chk("f2_adr0", icache_adr_o, 32'h300); tick;
        cyc(1, 0, 0, 0, 0, 0);                   chk("f2_adr1", icache_adr_o, 32'h304); tick;
        cyc(0, 1, 32'hBEEF_0001, 1, 32'h402, 0); chk("f2_req2", icache_req_o, 1'b0); tick;
        cyc(0, 1, 32'hBEEF_0002, 0, 0, 0);       chk("f2_adr3", icache_adr_o, 32'h400); chk("f2_req3", icache_req_o, 1'b1);
                                                 chk("f2_v3", instr_v_o, 1'b0); tick;
        cyc(1, 0, 0, 0, 0, 0);                   chk("f2_v4", instr_v_o, 1'b0); chk("f2_adr4", icache_adr_o, 32'h400); tick;
        cyc(0, 1, io(32'h400), 0, 0, 0);         chk("f2_v5", instr_v_o, 1'b0); tick;
        cyc(0, 0, 0, 1, 32'h500, 1);             chk("f2_v6", instr_v_o, 1'b1); chk("f2_pc6", pc_o, 32'h400);
                                                 chk("f2_instr6", instr_o, io(32'h400)); tick;
        cyc(1, 0, 0, 0, 0, 0);                   chk("f3_v7", instr_v_o, 1'b0); chk("f3_req7", icache_req_o, 1'b1);
                                                 chk("f3_adr7", icache_adr_o, 32'h500); tick;
        cyc(1, 0, 0, 0, 0, 0);                   chk("f3_adr8", icache_adr_o, 32'h504); tick;
        cyc(0, 1, 32'hCAFE_0001, 1, 32'h700, 0); chk("f3_req9", icache_req_o, 1'b0); tick;
        cyc(0, 0, 0, 1, 32'h800, 0);             chk("f3_req10", icache_req_o, 1'b0); tick;
        cyc(1, 1, 32'hCAFE_0002, 0, 0, 0);       chk("f3_adr11", icache_adr_o, 32'h800); chk("f3_req11", icache_req_o, 1'b1);
                                                 chk("f3_v11", instr_v_o, 1'b0); tick;
        cyc(0, 1, io(32'h800), 0, 0, 0);         chk("f3_v12", instr_v_o, 1'b0); tick;
        cyc(0, 0, 0, 0, 0, 0);                   chk("f3_v13", instr_v_o, 1'b1); chk("f3_pc13", pc_o, 32'h800);
                                                 chk("f3_instr13", instr_o, io(32'h800));

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/fetch_buffer.md
FETCH_BUFFER -- requirements
Module: fetch_buffer

Interface
REQ-001 Parameter XLEN, default 32 (from riscv package), address/PC width.
REQ-002 Parameter DEPTH, default 4, queue entries; power of two, >=2.
REQ-003 Parameter MAX_OUT, default 2, max outstanding icache requests; 1..DEPTH.
REQ-004 Single clock domain: clk is the only clock; reset is asynchronous and active-high.
REQ-005 clk  in  1  clock, all state on rising edge.
REQ-006 reset  in  1  asynchronous active-high reset.
REQ-007 reset_adr_i  in  XLEN  first fetch PC after reset.
REQ-008 icache_req_o  out  1  fetch request valid.
REQ-009 icache_adr_o  out  XLEN  fetch address, word aligned.
REQ-010 icache_gnt_i  in  1  request accepted this cycle, when icache_req_o=1.
REQ-011 icache_rvalid_i  in  1  response valid; responses return in request order.
REQ-012 icache_instr_i  in  32  response instruction.
REQ-013 flush_v_i  in  1  redirect from exe.
REQ-014 flush_pc_i  in  XLEN  redirect target.
REQ-015 instr_v_o  out  1  head entry valid to decoder.
REQ-016 instr_o  out  32  head instruction.
REQ-017 pc_o  out  XLEN  head PC.
REQ-018 dec_ready_i  in  1  decoder accepts head this cycle.

Function
REQ-019 Fetch PC register fpc holds the next address; icache_adr_o = fpc.
REQ-020 icache_req_o = !flush_v_i and (count + outstanding < DEPTH) and (outstanding < MAX_OUT).
REQ-021 On icache_req_o and icache_gnt_i: fpc += 4 (wraps modulo 2^XLEN); outstanding += 1; the request PC is pushed to an in-order PC tag list.
REQ-022 On icache_rvalid_i: outstanding -= 1; if discard = 0, push {tag PC, icache_instr_i} into the queue; otherwise drop the response and decrement discard.
REQ-023 Simultaneous grant and rvalid: outstanding is unchanged.
REQ-024 Pop occurs when instr_v_o and dec_ready_i; push and pop in the same cycle are allowed at any occupancy.
REQ-025 instr_v_o = (count != 0); instr_o/pc_o come combinationally from the head entry; latency is 1 cycle from rvalid to instr_v_o.
REQ-026 Credit rule REQ-020 guarantees no overflow; queue full with a response arriving is unreachable and asserted.
REQ-027 On flush_v_i: queue emptied; fpc <= flush_pc_i; discard <= outstanding minus (rvalid this cycle and discard = 0 ? 1 : 0), adjusted per REQ-022. A response arriving in the flush cycle is always dropped. First request to flush_pc_i issues the next cycle.
REQ-028 A pop in the flush cycle has no effect; instr_v_o is still shown that cycle.
REQ-029 Back-to-back flushes: the last one wins; discard accumulates correctly.
REQ-030 Flush with flush_pc_i[1:0] != 0: bits [1:0] are forced to 0.

Reset
REQ-031 While reset is high: icache_req_o=0, instr_v_o=0, instr_o=0, pc_o=0, count=0, outstanding=0, discard=0, fpc=reset_adr_i.
REQ-032 First request issues in the first clk edge cycle after reset falls.
REQ-033 Reset mid-operation drops all in-flight state; late responses after reset are ignored only if the icache is also reset, which is a system requirement.

Structure
REQ-034 The riscv package holds XLEN and typedef fetch_entry_t {pc, instr}.
REQ-035 The queue is sub-module fetch_fifo (parameter DEPTH, width of fetch_entry_t), with push/pop/clear/count ports.
REQ-036 The PC tag list is a MAX_OUT-deep FIFO local to fetch_buffer.

Verification
REQ-037 reset_adr_i=0x80000000, gnt=1, rvalid one cycle later, ready=1 -> adr sequence 0x80000000, 0x80000004, ...; instr_v_o steady 1 with matching pc_o.
REQ-038 ready=0, gnt=1, DEPTH=4 -> exactly 4 grants, then icache_req_o=0; ready=1 for one cycle -> exactly one new request.
REQ-039 Two outstanding requests (0x100, 0x104), flush to 0x200 before responses -> both responses dropped; first queued pc_o=0x200.
REQ-040 Flush in the same cycle as rvalid with one further outstanding -> both responses dropped; discard returns to 0.
REQ-041 gnt held 0 for 10 cycles -> icache_req_o and icache_adr_o stable; no state change.
REQ-042 Reset asserted with queue holding 3 entries -> instr_v_o=0 asynchronously; fpc=reset_adr_i.
